// File: rtl/sine_freq_meter.sv
// rtl/sine_freq_meter.sv - hysteresis-comparator frequency meter for a 14-bit offset-binary sine stream.
module sine_freq_meter #(
    parameter int GATE_LOG2 = 18,
    parameter int HYST      = 256,
    parameter int MIDSCALE  = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [13:0] sample_in,
    output logic [15:0] crossings,
    output logic [15:0] freq_word,
    output logic        meas_valid,
    output logic        saturated,
    output logic        signal_present
);

    localparam int          SHIFT = 18 - GATE_LOG2;
    localparam logic [14:0] TH_HI = 15'(MIDSCALE + HYST);
    localparam logic [14:0] TH_LO = 15'(MIDSCALE - HYST);
    localparam logic [13:0] MID14 = 14'(MIDSCALE);

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        REPORT
    } state_t;

    state_t                 state;
    logic [13:0]            s_q;
    logic                   cmp_high;
    logic [GATE_LOG2-1:0]   timer;
    logic [15:0]            count;
    logic                   sat;
    logic                   rise;
    logic                   fall;
    logic [23:0]            shifted;
    logic                   shift_ovf;

    // Thresholds widened to 15 bits so MIDSCALE+HYST cannot wrap.
    assign rise      = !cmp_high && ({1'b0, s_q} >= TH_HI);
    assign fall      = cmp_high && ({1'b0, s_q} <= TH_LO);
    assign shifted   = {8'd0, count} << SHIFT;
    assign shift_ovf = |shifted[23:16];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q      <= MID14;
            cmp_high <= 1'b0;
        end else begin
            s_q <= sample_in;
            if (rise) begin
                cmp_high <= 1'b1;
            end else if (fall) begin
                cmp_high <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            timer          <= '0;
            count          <= '0;
            sat            <= 1'b0;
            crossings      <= '0;
            freq_word      <= '0;
            meas_valid     <= 1'b0;
            saturated      <= 1'b0;
            signal_present <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!enable) begin
                state <= IDLE;
                timer <= '0;
                count <= '0;
                sat   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= GATE;
                        timer <= '0;
                        count <= '0;
                        sat   <= 1'b0;
                    end
                    GATE: begin
                        timer <= timer + 1'b1;
                        if (rise) begin
                            if (count == 16'hFFFF) begin
                                sat <= 1'b1;
                            end else begin
                                count <= count + 16'd1;
                            end
                        end
                        if (&timer) begin
                            state <= REPORT;
                        end
                    end
                    REPORT: begin
                        crossings      <= count;
                        freq_word      <= shift_ovf ? 16'hFFFF : shifted[15:0];
                        saturated      <= sat | shift_ovf;
                        signal_present <= (count >= 16'd2);
                        meas_valid     <= 1'b1;
                        state          <= GATE;
                        timer          <= '0;
                        // The crossing seen in the dead cycle opens the next window.
                        count          <= rise ? 16'd1 : 16'd0;
                        sat            <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sine_freq_meter.sv
// tb/tb_sine_freq_meter.sv - directed self-checking bench for sine_freq_meter with a 2^10-cycle gate.
`timescale 1ns/1ps
module tb_sine_freq_meter;

    localparam int GL    = 10;
    localparam int WIN   = (1 << GL) + 1;
    localparam int M_DC  = 0;
    localparam int M_DDS = 1;
    localparam int M_TOG = 2;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [13:0] sample_in;
    logic [15:0] crossings;
    logic [15:0] freq_word;
    logic        meas_valid;
    logic        saturated;
    logic        signal_present;

    int          checks;
    int          passed;
    int          mode;
    logic [13:0] dc_val;
    logic [15:0] fc;
    logic [13:0] tog_hi;
    logic [13:0] tog_lo;
    logic [17:0] phase;
    logic        tog;

    sine_freq_meter #(
        .GATE_LOG2(GL),
        .HYST(256),
        .MIDSCALE(8192)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .sample_in(sample_in),
        .crossings(crossings),
        .freq_word(freq_word),
        .meas_valid(meas_valid),
        .saturated(saturated),
        .signal_present(signal_present)
    );

    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    // Sample source: DC level, DDS sine model, or per-cycle toggle between two levels.
    initial begin
        int v;
        sample_in = 14'd8192;
        phase     = '0;
        tog       = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                M_DDS: begin
                    phase = phase + {2'b00, fc};
                    v = 8192 + $rtoi($floor(8191.0 * $sin(6.283185307179586 * real'(phase) / 262144.0) + 0.5));
                    sample_in = 14'(v);
                end
                M_TOG: begin
                    tog = ~tog;
                    sample_in = tog ? tog_hi : tog_lo;
                end
                default: sample_in = dc_val;
            endcase
        end
    end

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (meas_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic restart();
        enable = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        enable = 1'b1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        enable = 1'b0;
        mode   = M_DC;
        dc_val = 14'd8192;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (crossings !== 16'd0) $display("FAIL reset_crossings: got %0d expected 0", crossings); else passed++;
        checks++; if (freq_word !== 16'd0) $display("FAIL reset_freq_word: got %0d expected 0", freq_word); else passed++;
        checks++; if (meas_valid !== 1'b0) $display("FAIL reset_meas_valid: got %0b expected 0", meas_valid); else passed++;
        checks++; if (saturated !== 1'b0) $display("FAIL reset_saturated: got %0b expected 0", saturated); else passed++;
        checks++; if (signal_present !== 1'b0) $display("FAIL reset_signal_present: got %0b expected 0", signal_present); else passed++;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_dds(input logic [15:0] f, input int lo, input int hi);
        int n;
        logic [15:0] exp_fw;
        mode = M_DDS;
        fc   = f;
        restart();
        wait_valid(3 * WIN, n);
        checks++; if (n !== WIN + 1) $display("FAIL dds_latency: got %0d cycles expected %0d", n, WIN + 1); else passed++;
        checks++; if (!(crossings >= 16'(lo) && crossings <= 16'(hi))) $display("FAIL dds_crossings: got %0d expected %0d..%0d", crossings, lo, hi); else passed++;
        exp_fw = crossings << (18 - GL);
        checks++; if (freq_word !== exp_fw) $display("FAIL dds_freq_word: got %0d expected %0d", freq_word, exp_fw); else passed++;
        checks++; if (!(freq_word >= f - 16'd256 && freq_word <= f + 16'd256)) $display("FAIL dds_freq_vs_fc: got %0h expected %0h +-256", freq_word, f); else passed++;
        checks++; if (signal_present !== 1'b1) $display("FAIL dds_signal_present: got %0b expected 1", signal_present); else passed++;
        checks++; if (saturated !== 1'b0) $display("FAIL dds_saturated: got %0b expected 0", saturated); else passed++;
        @(posedge clk);
        #1;
        checks++; if (meas_valid !== 1'b0) $display("FAIL dds_strobe_width: got %0b expected 0", meas_valid); else passed++;
        wait_valid(3 * WIN, n);
        checks++; if (n !== WIN - 1) $display("FAIL dds_period: got %0d cycles expected %0d", n + 1, WIN); else passed++;
        checks++; if (!(crossings >= 16'(lo) && crossings <= 16'(hi))) $display("FAIL dds_crossings2: got %0d expected %0d..%0d", crossings, lo, hi); else passed++;
    endtask

    task automatic test_toggle(input logic [13:0] h, input logic [13:0] l, input logic [15:0] exp_cross,
                               input logic [15:0] exp_fw, input logic exp_sat, input logic exp_sp);
        int n;
        mode   = M_TOG;
        tog_hi = h;
        tog_lo = l;
        restart();
        wait_valid(3 * WIN, n);
        checks++; if (n !== WIN + 1) $display("FAIL tog_latency: got %0d cycles expected %0d", n, WIN + 1); else passed++;
        checks++; if (crossings !== exp_cross) $display("FAIL tog_crossings(%0d/%0d): got %0d expected %0d", h, l, crossings, exp_cross); else passed++;
        checks++; if (freq_word !== exp_fw) $display("FAIL tog_freq_word(%0d/%0d): got %0h expected %0h", h, l, freq_word, exp_fw); else passed++;
        checks++; if (saturated !== exp_sat) $display("FAIL tog_saturated(%0d/%0d): got %0b expected %0b", h, l, saturated, exp_sat); else passed++;
        checks++; if (signal_present !== exp_sp) $display("FAIL tog_signal_present(%0d/%0d): got %0b expected %0b", h, l, signal_present, exp_sp); else passed++;
    endtask

    task automatic test_dc();
        int n;
        mode   = M_DC;
        dc_val = 14'd8192;
        restart();
        wait_valid(3 * WIN, n);
        checks++; if (n !== WIN + 1) $display("FAIL dc_latency: got %0d cycles expected %0d", n, WIN + 1); else passed++;
        checks++; if (crossings !== 16'd0) $display("FAIL dc_crossings: got %0d expected 0", crossings); else passed++;
        checks++; if (freq_word !== 16'd0) $display("FAIL dc_freq_word: got %0d expected 0", freq_word); else passed++;
        checks++; if (saturated !== 1'b0) $display("FAIL dc_saturated: got %0b expected 0", saturated); else passed++;
        checks++; if (signal_present !== 1'b0) $display("FAIL dc_signal_present: got %0b expected 0", signal_present); else passed++;
    endtask

    task automatic test_abort();
        int n;
        int seen;
        logic [15:0] held_cross;
        logic [15:0] held_fw;
        mode = M_DDS;
        fc   = 16'h0400;
        restart();
        wait_valid(3 * WIN, n);
        held_cross = crossings;
        held_fw    = freq_word;
        seen = 0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (meas_valid) seen++;
        end
        enable = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (meas_valid) seen++;
        end
        checks++; if (crossings !== held_cross) $display("FAIL abort_hold_crossings: got %0d expected %0d", crossings, held_cross); else passed++;
        checks++; if (freq_word !== held_fw) $display("FAIL abort_hold_freq_word: got %0d expected %0d", freq_word, held_fw); else passed++;
        enable = 1'b1;
        wait_valid(3 * WIN, n);
        checks++; if (seen !== 0) $display("FAIL abort_no_valid: got %0d strobes expected 0", seen); else passed++;
        checks++; if (n !== WIN + 1) $display("FAIL abort_relatency: got %0d cycles expected %0d", n, WIN + 1); else passed++;
    endtask

    task automatic test_reset_mid_gate();
        int n;
        int seen;
        mode   = M_TOG;
        tog_hi = 14'd16383;
        tog_lo = 14'd0;
        restart();
        wait_valid(3 * WIN, n);
        repeat (400) @(posedge clk);
        #2;
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        checks++; if (crossings !== 16'd0) $display("FAIL rst_async_crossings: got %0d expected 0", crossings); else passed++;
        checks++; if (freq_word !== 16'd0) $display("FAIL rst_async_freq_word: got %0h expected 0", freq_word); else passed++;
        checks++; if (saturated !== 1'b0) $display("FAIL rst_async_saturated: got %0b expected 0", saturated); else passed++;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        repeat (5000) begin
            @(posedge clk);
            #1;
            if (meas_valid) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL rst_idle_valid: got %0d strobes expected 0", seen); else passed++;
        checks++; if (crossings !== 16'd0) $display("FAIL rst_idle_crossings: got %0d expected 0", crossings); else passed++;
        checks++; if (signal_present !== 1'b0) $display("FAIL rst_idle_signal_present: got %0b expected 0", signal_present); else passed++;
        enable = 1'b1;
        wait_valid(3 * WIN, n);
        checks++; if (n !== WIN + 1) $display("FAIL rst_restart_latency: got %0d cycles expected %0d", n, WIN + 1); else passed++;
        checks++; if (crossings !== 16'd512) $display("FAIL rst_restart_crossings: got %0d expected 512", crossings); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        fc     = 16'h0400;
        tog_hi = 14'd8192;
        tog_lo = 14'd8192;
        test_reset();
        test_dds(16'h0400, 3, 5);
        test_dds(16'h2000, 31, 33);
        test_toggle(14'd8392, 14'd7992, 16'd0, 16'd0, 1'b0, 1'b0);
        test_toggle(14'd8492, 14'd7892, 16'd512, 16'hFFFF, 1'b1, 1'b1);
        test_dc();
        test_toggle(14'd16383, 14'd0, 16'd512, 16'hFFFF, 1'b1, 1'b1);
        test_abort();
        test_reset_mid_gate();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
